// File: rtl/vga_str_pkg.sv
// Shared strRGB stream field positions and default 640x480@60 raster timing.
// Every stream stage imports this instead of carrying its own field macros.
package vga_str_pkg;

  localparam int STR_ACTIVE = 0;
  localparam int STR_VS     = 1;
  localparam int STR_HS     = 2;
  localparam int STR_YC_LSB = 3;
  localparam int STR_YC_MSB = 12;
  localparam int STR_XC_LSB = 13;
  localparam int STR_XC_MSB = 22;
  localparam int STR_R      = 23;
  localparam int STR_G      = 24;
  localparam int STR_B      = 25;
  localparam int STR_W      = 26;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CNT_MAX = 1024;

endpackage

// File: rtl/vga_tim_axis.sv
// One raster axis: a wrapping position counter plus decoded active/sync flags.
// The flags are combinational from the counter; the top registers them.
module vga_tim_axis #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       step,
  output logic [9:0] count,
  output logic       wrap,
  output logic       active,
  output logic       sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0] LAST     = 11'(TOTAL - 1);
  localparam logic [10:0] ACT_END  = 11'(ACTIVE);
  localparam logic [10:0] SYNC_BEG = 11'(ACTIVE + FP);
  localparam logic [10:0] SYNC_END = 11'(ACTIVE + FP + SYNC);

  logic [10:0] cnt_x;

  assign cnt_x  = {1'b0, count};
  assign wrap   = (cnt_x == LAST);
  assign active = (cnt_x < ACT_END);
  assign sync   = ((cnt_x >= SYNC_BEG) && (cnt_x < SYNC_END)) ? POL : ~POL;

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 10'd1;
    end
  end

endmodule

// File: rtl/vga_str_gen.sv
// Raster timing generator at the head of the strRGB pipeline: emits coordinates,
// sync and active flags with colour bits cleared, one registered word per px_clk.
module vga_str_gen
  import vga_str_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic             px_clk,
  input  logic             reset,
  output logic [STR_W-1:0] strRGB_o,
  output logic             frame_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > CNT_MAX) begin : g_h_total_chk
    $fatal(1, "vga_str_gen: H_TOTAL exceeds 10-bit XC range");
  end
  if (V_TOTAL > CNT_MAX) begin : g_v_total_chk
    $fatal(1, "vga_str_gen: V_TOTAL exceeds 10-bit YC range");
  end

  logic [9:0]       hc, vc;
  logic             h_wrap, v_wrap;
  logic             h_act, v_act;
  logic             hs, vs;
  logic             first_px;
  logic [STR_W-1:0] word_next;

  vga_tim_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h_axis (
    .px_clk(px_clk), .reset(reset), .step(1'b1),
    .count(hc), .wrap(h_wrap), .active(h_act), .sync(hs)
  );

  vga_tim_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v_axis (
    .px_clk(px_clk), .reset(reset), .step(h_wrap),
    .count(vc), .wrap(v_wrap), .active(v_act), .sync(vs)
  );

  always_comb begin
    word_next                          = '0;
    word_next[STR_ACTIVE]              = h_act && v_act;
    word_next[STR_VS]                  = vs;
    word_next[STR_HS]                  = hs;
    word_next[STR_YC_MSB:STR_YC_LSB]   = vc;
    word_next[STR_XC_MSB:STR_XC_LSB]   = hc;
  end

  // first_px marks counters sitting at (0,0): right after reset or after the last pixel
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      strRGB_o         <= '0;
      strRGB_o[STR_HS] <= ~HS_POL;
      strRGB_o[STR_VS] <= ~VS_POL;
      frame_o          <= 1'b0;
      first_px         <= 1'b1;
    end else begin
      strRGB_o         <= word_next;
      frame_o          <= first_px;
      first_px         <= h_wrap && v_wrap;
    end
  end

endmodule
